step_sched: RTL and testbench

STEP_SCHED -- requirements
Module: step_sched

---
 rtl/step_sched.sv | 109 ++++++++++
 tb/tb_step_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/step_sched.sv
// Round-robin step scheduler: grants one of four channels, captures its sample,
// and advances that channel's phase/cycle counters when the sample changes.
module step_sched #(
    parameter int NCH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] sample_bus,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        done,
    output logic [1:0]  done_chan,
    output logic        done_changed,
    output logic [2:0]  done_phase,
    output logic [7:0]  done_cycles
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  ch, last_ch, pick, idx;
    logic        found;
    logic [3:0]  samp_sel, samp_p1;
    logic        changed_p1;
    logic [3:0]  prev   [NCH];
    logic [2:0]  phase  [NCH];
    logic [7:0]  cycles [NCH];
    logic [2:0]  phase_nxt;
    logic [7:0]  cycles_nxt;

    // Search starts one past the last served channel and wraps on the 2-bit index.
    always_comb begin
        pick  = last_ch;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = last_ch + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = CAPTURE;
            CAPTURE: state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign grant      = busy ? (4'b0001 << ch) : 4'b0000;
    assign samp_sel   = sample_bus[{ch, 2'b00} +: 4];
    assign phase_nxt  = changed_p1 ? phase[ch] + 3'd1 : phase[ch];
    assign cycles_nxt = (changed_p1 && phase[ch] == 3'd0) ? cycles[ch] + 8'd1 : cycles[ch];

    // Capture stage: sample and compare result are only consumed in UPDATE.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            samp_p1    <= samp_sel;
            changed_p1 <= (samp_sel != prev[ch]);
        end
    end

    // Update stage: per-channel state and completion report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ch           <= 2'd0;
            last_ch      <= 2'd3;
            done         <= 1'b0;
            done_chan    <= 2'd0;
            done_changed <= 1'b0;
            done_phase   <= 3'd0;
            done_cycles  <= 8'd0;
            for (int i = 0; i < NCH; i++) begin
                prev[i]   <= 4'h0;
                phase[i]  <= 3'd0;
                cycles[i] <= 8'd0;
            end
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (state == IDLE && found)
                ch <= pick;
            if (state == UPDATE) begin
                prev[ch]     <= samp_p1;
                phase[ch]    <= phase_nxt;
                cycles[ch]   <= cycles_nxt;
                last_ch      <= ch;
                done         <= 1'b1;
                done_chan    <= ch;
                done_changed <= changed_p1;
                done_phase   <= phase_nxt;
                done_cycles  <= cycles_nxt;
            end
        end
    end

endmodule

// File: tb/tb_step_sched.sv
// Directed bench for step_sched: reset, single-channel, change counting with
// wrap, round-robin order, sample timing, and mid-transaction reset.
module tb_step_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] sample_bus;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic [1:0]  done_chan;
    logic        done_changed;
    logic [2:0]  done_phase;
    logic [7:0]  done_cycles;

    int total = 0;
    int bad   = 0;

    step_sched #(.NCH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .sample_bus   (sample_bus),
        .grant        (grant),
        .busy         (busy),
        .done         (done),
        .done_chan    (done_chan),
        .done_changed (done_changed),
        .done_phase   (done_phase),
        .done_cycles  (done_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction starting from IDLE. bus_cap is present only during
    // the CAPTURE cycle; bus_other is present in the other two cycles.
    task automatic txn(input string tag, input logic [3:0] rq, input logic [3:0] rq_mid,
                       input logic [15:0] bus_cap, input logic [15:0] bus_other,
                       input logic [3:0] eg, input logic [1:0] ech, input logic echg,
                       input logic [2:0] eph, input logic [7:0] ecy);
        req        = rq;
        sample_bus = bus_other;
        tick;
        chk({tag, ".cap_grant"}, 32'(grant), 32'(eg));
        chk({tag, ".cap_busy"},  32'(busy), 32'd1);
        chk({tag, ".cap_done"},  32'(done), 32'd0);
        req        = rq_mid;
        sample_bus = bus_cap;
        tick;
        chk({tag, ".upd_grant"}, 32'(grant), 32'(eg));
        chk({tag, ".upd_busy"},  32'(busy), 32'd1);
        sample_bus = bus_other;
        tick;
        chk({tag, ".done"},      32'(done), 32'd1);
        chk({tag, ".idle_grant"}, 32'(grant), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".chan"},      32'(done_chan), 32'(ech));
        chk({tag, ".changed"},   32'(done_changed), 32'(echg));
        chk({tag, ".phase"},     32'(done_phase), 32'(eph));
        chk({tag, ".cycles"},    32'(done_cycles), 32'(ecy));
    endtask

    task automatic qtxn(input logic [15:0] bus);
        req        = 4'b0001;
        sample_bus = bus;
        tick;
        tick;
        tick;
    endtask

    logic [15:0] bus_n;

    initial begin
        reset      = 1'b1;
        req        = 4'b0000;
        sample_bus = 16'h0000;
        #2;
        chk("rst.grant",   32'(grant), 32'd0);
        chk("rst.busy",    32'(busy), 32'd0);
        chk("rst.done",    32'(done), 32'd0);
        chk("rst.chan",    32'(done_chan), 32'd0);
        chk("rst.changed", 32'(done_changed), 32'd0);
        chk("rst.phase",   32'(done_phase), 32'd0);
        chk("rst.cycles",  32'(done_cycles), 32'd0);
        tick;
        reset = 1'b0;
        tick;
        tick;
        chk("idle.grant", 32'(grant), 32'd0);
        chk("idle.busy",  32'(busy), 32'd0);
        chk("idle.done",  32'(done), 32'd0);

        // First change on ch0: phase 0->1 bumps cycles to 1.
        txn("t1", 4'b0001, 4'b0001, 16'h0005, 16'h0005, 4'b0001, 2'd0, 1'b1, 3'd1, 8'd1);
        // Same sample repeatedly: nothing advances.
        txn("t2", 4'b0001, 4'b0001, 16'h0005, 16'h0005, 4'b0001, 2'd0, 1'b0, 3'd1, 8'd1);
        txn("t3", 4'b0001, 4'b0001, 16'h0005, 16'h0005, 4'b0001, 2'd0, 1'b0, 3'd1, 8'd1);
        // Bus differs outside CAPTURE and req drops mid-transaction: still no change, still done.
        txn("glitch", 4'b0001, 4'b0000, 16'h0005, 16'h000A, 4'b0001, 2'd0, 1'b0, 3'd1, 8'd1);
        tick;
        chk("pulse.done",  32'(done), 32'd0);
        chk("hold.chan",   32'(done_chan), 32'd0);
        chk("hold.phase",  32'(done_phase), 32'd1);
        chk("hold.cycles", 32'(done_cycles), 32'd1);
        chk("hold.busy",   32'(busy), 32'd0);

        // Change n uses 0xA for even n, 0x5 for odd n; phase = n mod 8, cycles = ceil(n/8) mod 256.
        for (int n = 2; n <= 9; n++) begin
            bus_n = (n % 2 == 0) ? 16'h000A : 16'h0005;
            txn($sformatf("tog%0d", n), 4'b0001, 4'b0001, bus_n, bus_n, 4'b0001, 2'd0, 1'b1,
                3'(n % 8), 8'((n + 7) / 8));
        end
        for (int n = 10; n <= 2039; n++) begin
            bus_n = (n % 2 == 0) ? 16'h000A : 16'h0005;
            qtxn(bus_n);
        end
        txn("wrap2040", 4'b0001, 4'b0001, 16'h000A, 16'h000A, 4'b0001, 2'd0, 1'b1, 3'd0, 8'd255);
        txn("wrap2041", 4'b0001, 4'b0001, 16'h0005, 16'h0005, 4'b0001, 2'd0, 1'b1, 3'd1, 8'd0);
        req = 4'b0000;

        // Fresh reset, then all four requesting: order 0,1,2,3,0.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            txn($sformatf("rr%0d", i), 4'b1111, 4'b1111, 16'h5555, 16'h5555,
                4'(4'b0001 << (i % 4)), 2'(i % 4), (i < 4), 3'd1, 8'd1);
        end
        req = 4'b0000;

        // Reset during CAPTURE of ch2 discards the transaction.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick;
        req        = 4'b0100;
        sample_bus = 16'h0500;
        tick;
        chk("mid.grant_before", 32'(grant), 32'b0100);
        #2;
        reset = 1'b1;
        #1;
        chk("mid.grant_async", 32'(grant), 32'd0);
        chk("mid.busy_async",  32'(busy), 32'd0);
        #1;
        reset = 1'b0;
        req   = 4'b0000;
        tick;
        chk("mid.done1", 32'(done), 32'd0);
        tick;
        chk("mid.done2", 32'(done), 32'd0);
        tick;
        chk("mid.done3", 32'(done), 32'd0);
        // ch0 first, then ch2 with sample 0 shows prev/phase/cycles were untouched.
        txn("post_ch0", 4'b0101, 4'b0101, 16'h0000, 16'h0000, 4'b0001, 2'd0, 1'b0, 3'd0, 8'd0);
        txn("post_ch2", 4'b0101, 4'b0101, 16'h0000, 16'h0000, 4'b0100, 2'd2, 1'b0, 3'd0, 8'd0);
        req = 4'b0000;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
